aftab_div_sequencer: RTL and testbench
======================================

AFTAB_DIV_SEQUENCER -- requirements
Module: aftab_div_sequencer

Interface
REQ-001 SHALL have parameter len, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port startDivide, input, 1, a request strobe sampled only in IDLE.
REQ-005 SHALL have port signedOp, input, 1, selecting two's-complement (1) or unsigned (0) operands.
REQ-006 SHALL have port remSel, input, 1, selecting the remainder (1) or the quotient (0) as result.
REQ-007 SHALL have ports dividend and divisor, input, len each, the operands, sampled with startDivide.
REQ-008 SHALL have port result, output, len, the registered quotient or remainder.
REQ-009 SHALL have port doneDivide, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have ports startCore (output, 1), coreDividend and coreDivisor (output, len, operand magnitudes), coreQ and coreR (input, len) and doneCore (input, 1), forming the handshake to the unsigned divider core.

Function
REQ-012 SHALL implement the states IDLE, PREP, START, WAIT, FIX and DONE.
REQ-013 In IDLE, startDivide=1 SHALL latch the operands, signedOp and remSel, and the next state SHALL be PREP; otherwise the FSM SHALL stay in IDLE.
REQ-014 PREP SHALL register the magnitudes (two's-complement negation of negative operands when signedOp=1, unchanged otherwise) onto coreDividend and coreDivisor, and SHALL record negQ = signedOp & (sign(dividend) ^ sign(divisor)) & (divisor != 0) and negR = signedOp & sign(dividend).
REQ-015 START SHALL assert startCore for exactly one cycle, and the next state SHALL be WAIT.
REQ-016 WAIT SHALL hold until doneCore=1 and SHALL then capture coreQ and coreR; doneCore outside WAIT SHALL be ignored.
REQ-017 FIX SHALL register result as negQ ? -coreQ : coreQ when remSel=0, and as negR ? -coreR : coreR when remSel=1.
REQ-018 DONE SHALL assert doneDivide for one cycle and then return to IDLE; result SHALL hold until the next FIX.
REQ-019 Latency from startDivide to doneDivide SHALL be 4 cycles plus the core's startCore-to-doneCore latency.
REQ-020 startDivide while busy=1 SHALL be ignored, with no queuing.
REQ-021 Signed overflow (dividend = -2^(len-1), divisor = -1) SHALL yield quotient -2^(len-1) and remainder 0 with no special path.
REQ-022 Divide by zero SHALL yield quotient all-ones and remainder equal to the original dividend, for both signed and unsigned operation; without the bypass, FIX SHALL force these values regardless of the core outputs.
REQ-023 coreDividend and coreDivisor SHALL stay stable from PREP until the FSM leaves WAIT.

Reset
REQ-024 On rst=0, the FSM SHALL enter IDLE, and result, startCore, doneDivide, busy, coreDividend and coreDivisor SHALL be 0, taking effect immediately and including mid-operation.
REQ-025 After a mid-operation reset, a late doneCore SHALL NOT produce doneDivide.

Configuration
REQ-026 With macro AFTAB_DIV_ZERO_BYPASS_EN defined, PREP with divisor = 0 SHALL go directly to FIX using the REQ-022 values, never asserting startCore, for a total latency of 3 cycles.
REQ-027 Without AFTAB_DIV_ZERO_BYPASS_EN, a zero divisor SHALL follow the normal START/WAIT path, with REQ-022 enforced in FIX.

Verification
REQ-028 Unsigned 100/7 with remSel=0, then remSel=1 -> result 14, then 2; doneDivide exactly once per request.
REQ-029 Signed -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1 (0xFFFFFFFF); signed 7/-2 -> quotient -3, remainder 1.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-031 Signed -5/0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB; startCore is never asserted and latency is 3 with AFTAB_DIV_ZERO_BYPASS_EN, and latency is 4 plus the core latency without it.
REQ-032 rst pulsed low during WAIT, then doneCore driven high -> all outputs 0, no doneDivide, and the next request completes correctly.
REQ-033 startDivide held high for the whole operation -> exactly one operation, with the next one starting only after return to IDLE.

Source files
------------

// File: rtl/aftab_div_sequencer.sv
// Sequencer that wraps an unsigned divider core to provide signed/unsigned
// division with quotient or remainder selection.
// Optional feature: define AFTAB_DIV_ZERO_BYPASS_EN to skip the core entirely
// for a zero divisor (PREP goes straight to FIX).
module aftab_div_sequencer #(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           startDivide,
    input  logic           signedOp,
    input  logic           remSel,
    input  logic [len-1:0] dividend,
    input  logic [len-1:0] divisor,
    output logic [len-1:0] result,
    output logic           doneDivide,
    output logic           busy,
    output logic           startCore,
    output logic [len-1:0] coreDividend,
    output logic [len-1:0] coreDivisor,
    input  logic [len-1:0] coreQ,
    input  logic [len-1:0] coreR,
    input  logic           doneCore
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } stateType;

    stateType pState, nState;

    logic [len-1:0] opA, opB;
    logic           sgnOp, remOp;
    logic           negQ, negR, divZero;
    logic [len-1:0] qReg, rReg;
    logic [len-1:0] magA, magB;
    logic           opBZero;

    // Operand magnitudes presented to the unsigned core
    always_comb begin
        magA    = (sgnOp && opA[len-1]) ? -opA : opA;
        magB    = (sgnOp && opB[len-1]) ? -opB : opB;
        opBZero = (opB == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pState <= IDLE;
        else      pState <= nState;
    end

    // Next-state logic and state-decoded control outputs
    always_comb begin
        nState     = pState;
        startCore  = 1'b0;
        doneDivide = 1'b0;
        busy       = 1'b1;
        case (pState)
            IDLE: begin
                busy = 1'b0;
                if (startDivide) nState = PREP;
            end
            PREP: begin
`ifdef AFTAB_DIV_ZERO_BYPASS_EN
                if (opBZero) nState = FIX;
                else         nState = START;
`else
                nState = START;
`endif
            end
            START: begin
                startCore = 1'b1;
                nState    = WAIT;
            end
            WAIT: begin
                if (doneCore) nState = FIX;
            end
            FIX: begin
                nState = DONE;
            end
            DONE: begin
                doneDivide = 1'b1;
                nState     = IDLE;
            end
            default: begin
                busy   = 1'b0;
                nState = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, magnitude prep, core capture and sign fix-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opA          <= '0;
            opB          <= '0;
            sgnOp        <= 1'b0;
            remOp        <= 1'b0;
            negQ         <= 1'b0;
            negR         <= 1'b0;
            divZero      <= 1'b0;
            qReg         <= '0;
            rReg         <= '0;
            coreDividend <= '0;
            coreDivisor  <= '0;
            result       <= '0;
        end else begin
            case (pState)
                IDLE: begin
                    if (startDivide) begin
                        opA   <= dividend;
                        opB   <= divisor;
                        sgnOp <= signedOp;
                        remOp <= remSel;
                    end
                end
                PREP: begin
                    coreDividend <= magA;
                    coreDivisor  <= magB;
                    negQ         <= sgnOp & (opA[len-1] ^ opB[len-1]) & ~opBZero;
                    negR         <= sgnOp & opA[len-1];
                    divZero      <= opBZero;
                end
                WAIT: begin
                    if (doneCore) begin
                        qReg <= coreQ;
                        rReg <= coreR;
                    end
                end
                FIX: begin
                    // zero divisor ignores the core: quotient all-ones, remainder = raw dividend
                    if (divZero)    result <= remOp ? opA : '1;
                    else if (remOp) result <= negR ? -rReg : rReg;
                    else            result <= negQ ? -qReg : qReg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_div_sequencer.sv
// Self-checking bench for aftab_div_sequencer with a behavioural divider core.
// Honours AFTAB_DIV_ZERO_BYPASS_EN when computing expected latency/core starts.
module tb_aftab_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        startDivide, signedOp, remSel;
    logic [31:0] dividend, divisor;
    logic [31:0] result;
    logic        doneDivide, busy, startCore;
    logic [31:0] coreDividend, coreDivisor;
    logic [31:0] coreQ, coreR;
    logic        doneCore;

    aftab_div_sequencer #(.len(32)) dut (
        .clk(clk), .rst(rst), .startDivide(startDivide), .signedOp(signedOp),
        .remSel(remSel), .dividend(dividend), .divisor(divisor), .result(result),
        .doneDivide(doneDivide), .busy(busy), .startCore(startCore),
        .coreDividend(coreDividend), .coreDivisor(coreDivisor),
        .coreQ(coreQ), .coreR(coreR), .doneCore(doneCore)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          startCyc;
        int          lat;
        int          startBase;
        int          starts;
    } expT;

    expT  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   startCnt = 0;
    int   doneCnt = 0;
    int   coreLat = 3;
    int   coreCnt = 0;
    logic [31:0] coreQm = '0, coreRm = '0;

    // Behavioural core: doneCore pulses coreLat cycles after the startCore cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (startCore) begin
            startCnt <= startCnt + 1;
            coreCnt  <= coreLat;
            if (coreDivisor != 0) begin
                coreQm <= coreDividend / coreDivisor;
                coreRm <= coreDividend % coreDivisor;
            end else begin
                coreQm <= 32'h1234_5678;
                coreRm <= 32'h0BAD_F00D;
            end
        end else if (coreCnt > 0) begin
            coreCnt <= coreCnt - 1;
        end
    end
    assign doneCore = (coreCnt == 1);
    assign coreQ    = doneCore ? coreQm : 32'hA5A5_A5A5;
    assign coreR    = doneCore ? coreRm : 32'h5A5A_5A5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT signals completion
    always @(negedge clk) begin
        if (rst === 1'b1 && doneDivide === 1'b1) begin
            doneCnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpectedDone: doneDivide at cycle %0d with nothing pending", cyc);
            end else begin
                expT e;
                e = sb.pop_front();
                chk({e.name, ".result"}, result, e.res);
                chk({e.name, ".latency"}, 32'(cyc - e.startCyc), 32'(e.lat));
                chk({e.name, ".coreStarts"}, 32'(startCnt - e.startBase), 32'(e.starts));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input string name, input logic [31:0] exp, input bit zeroDiv);
        expT e;
        e.name      = name;
        e.res       = exp;
        e.startCyc  = cyc;
        e.startBase = startCnt;
`ifdef AFTAB_DIV_ZERO_BYPASS_EN
        e.lat    = zeroDiv ? 3 : 4 + coreLat;
        e.starts = zeroDiv ? 0 : 1;
`else
        e.lat    = 4 + coreLat;
        e.starts = 1;
`endif
        sb.push_back(e);
    endtask

    task automatic waitDone(input string name, input int target);
        for (int i = 0; i < 100 && doneCnt < target; i++) tick();
        if (doneCnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: doneCount %0d, expected %0d", name, doneCnt, target);
        end
        tick();
    endtask

    task automatic runOp(input string name, input logic s, input logic rs,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit zeroDiv);
        int base;
        base        = doneCnt;
        signedOp    = s;
        remSel      = rs;
        dividend    = a;
        divisor     = b;
        startDivide = 1'b1;
        pushExp(name, exp, zeroDiv);
        tick();
        startDivide = 1'b0;
        dividend    = 32'hDEAD_BEEF;
        divisor     = 32'hCAFE_F00D;
        waitDone(name, base + 1);
    endtask

    initial begin
        int base;
        int lat;
        rst = 1'b0;
        startDivide = 1'b0; signedOp = 1'b0; remSel = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) tick();
        chk("rst.result", result, 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.startCore", 32'(startCore), 32'h0);
        chk("rst.doneDivide", 32'(doneDivide), 32'h0);
        chk("rst.coreDividend", coreDividend, 32'h0);
        chk("rst.coreDivisor", coreDivisor, 32'h0);
        rst = 1'b1;
        repeat (2) tick();

        runOp("u100div7.q",   1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
        runOp("u100div7.r",   1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0);
        runOp("sM7div2.q",    1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        runOp("sM7div2.r",    1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        runOp("s7divM2.q",    1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        runOp("s7divM2.r",    1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        runOp("sOvf.q",       1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        runOp("sOvf.r",       1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        runOp("sM5div0.q",    1'b1, 1'b0, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, 1'b1);
        runOp("sM5div0.r",    1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 1'b1);
        runOp("u9div0.q",     1'b0, 1'b0, 32'd9, 32'h0, 32'hFFFF_FFFF, 1'b1);
        runOp("u9div0.r",     1'b0, 1'b1, 32'd9, 32'h0, 32'd9, 1'b1);
        runOp("uBigU.q",      1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);

        // Reset pulsed while the core is still working
        coreLat     = 8;
        base        = doneCnt;
        signedOp    = 1'b0; remSel = 1'b0;
        dividend    = 32'd1000; divisor = 32'd10;
        startDivide = 1'b1;
        tick();
        startDivide = 1'b0;
        repeat (4) tick();
        chk("midRst.busyBefore", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("midRst.result", result, 32'h0);
        chk("midRst.busy", 32'(busy), 32'h0);
        chk("midRst.startCore", 32'(startCore), 32'h0);
        chk("midRst.doneDivide", 32'(doneDivide), 32'h0);
        chk("midRst.coreDividend", coreDividend, 32'h0);
        chk("midRst.coreDivisor", coreDivisor, 32'h0);
        tick();
        rst = 1'b1;
        repeat (15) tick();
        chk("midRst.noDone", 32'(doneCnt), 32'(base));
        coreLat = 3;
        runOp("postRst.q", 1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 1'b0);

        // startDivide held high: one op per trip through IDLE, operands latched at start
        lat         = 4 + coreLat;
        base        = doneCnt;
        signedOp    = 1'b0; remSel = 1'b0;
        dividend    = 32'd50; divisor = 32'd6;
        startDivide = 1'b1;
        pushExp("hold1.q", 32'd8, 1'b0);
        tick();
        tick();
        signedOp = 1'b1; remSel = 1'b1;
        dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        repeat (lat - 1) tick();
        pushExp("hold2.r", 32'hFFFF_FFFE, 1'b0);
        tick();
        startDivide = 1'b0;
        waitDone("hold", base + 2);
        repeat (10) tick();

        chk("scoreboardEmpty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL globalTimeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
